// File: rtl/gray_counter.sv
// Binary up/down counter with a registered Gray-code image of the count.
// The Gray output moves one bit per count step, so it is safe to sample from another clock domain.
module gray_counter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_bin,
   output logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX_VAL  = '1;
   localparam logic [WIDTH-1:0] ZERO_VAL = '0;
   localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);

   logic [WIDTH-1:0] bin_next;
   logic [WIDTH-1:0] gray_next;
   logic             wrap_next;

   // Next count: load beats enable, enable beats hold.
   always_comb begin
      bin_next  = bin;
      wrap_next = 1'b0;
      if (load) begin
         bin_next = load_bin;
      end else if (en) begin
         if (up) begin
            bin_next  = bin + ONE_VAL;
            wrap_next = (bin == MAX_VAL);
         end else begin
            bin_next  = bin - ONE_VAL;
            wrap_next = (bin == ZERO_VAL);
         end
      end
   end

   // Gray is encoded from the next count so it lands in the same cycle as bin.
   always_comb begin
      gray_next = bin_next ^ (bin_next >> 1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin  <= '0;
         gray <= '0;
         wrap <= 1'b0;
      end else begin
         bin  <= bin_next;
         gray <= gray_next;
         wrap <= wrap_next;
      end
   end

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter: directed scenarios plus randomized
// traffic against an arithmetic reference model of the count.
module tb_gray_counter;

   localparam int unsigned WIDTH = 4;
   localparam int          MODV  = 1 << WIDTH;

   logic             clk;
   logic             rst;
   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_bin;
   logic [WIDTH-1:0] bin;
   logic [WIDTH-1:0] gray;
   logic             wrap;

   int checks;
   int errors;

   // Reference model state
   int m_bin;
   bit m_wrap;

   gray_counter #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
      .load_bin(load_bin), .bin(bin), .gray(gray), .wrap(wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int exp_gray(input int b);
      return b ^ (b / 2);
   endfunction

   function automatic int popc(input logic [WIDTH-1:0] x);
      int n = 0;
      for (int i = 0; i < int'(WIDTH); i++) if (x[i]) n++;
      return n;
   endfunction

   task automatic model_step();
      m_wrap = 1'b0;
      if (load) begin
         m_bin = int'(load_bin);
      end else if (en) begin
         if (up) begin
            m_wrap = (m_bin == MODV - 1);
            m_bin  = (m_bin + 1) % MODV;
         end else begin
            m_wrap = (m_bin == 0);
            m_bin  = (m_bin + MODV - 1) % MODV;
         end
      end
   endtask

   // One clock: apply currently driven inputs, advance model, land at edge+1.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic check_model(input string name);
      checks++;
      if (bin !== WIDTH'(m_bin) || gray !== WIDTH'(exp_gray(m_bin)) || wrap !== m_wrap) begin
         errors++;
         $display("FAIL %s: bin=%h gray=%h wrap=%b, want bin=%h gray=%h wrap=%b", name,
                  bin, gray, wrap, WIDTH'(m_bin), WIDTH'(exp_gray(m_bin)), m_wrap);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      m_bin  = 0;
      m_wrap = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; load_bin = '0;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (bin !== '0 || gray !== '0 || wrap !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: bin=%h gray=%h wrap=%b, want 0 0 0", bin, gray, wrap);
      end
      en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      m_bin = 0; m_wrap = 1'b0;
      @(posedge clk); #1;
      check_model("reset_hold");
   endtask

   task automatic test_up_count();
      logic [WIDTH-1:0] seq [16];
      logic [WIDTH-1:0] prev;
      seq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
              4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
      do_reset();
      en = 1'b1; up = 1'b1; load = 1'b0;
      for (int i = 0; i < 16; i++) begin
         prev = gray;
         tick();
         checks++;
         if (gray !== seq[i] || wrap !== (i == 15)) begin
            errors++;
            $display("FAIL up_seq[%0d]: gray=%h wrap=%b, want gray=%h wrap=%b",
                     i, gray, wrap, seq[i], (i == 15));
         end
         checks++;
         if (popc(prev ^ gray) != 1) begin
            errors++;
            $display("FAIL up_onebit[%0d]: %h -> %h changes %0d bits, want 1",
                     i, prev, gray, popc(prev ^ gray));
         end
      end
      en = 1'b0;
   endtask

   task automatic test_down_wrap();
      do_reset();
      en = 1'b1; up = 1'b0; load = 1'b0;
      tick();
      checks++;
      if (bin !== 4'hF || gray !== 4'h8 || wrap !== 1'b1) begin
         errors++;
         $display("FAIL down_wrap: bin=%h gray=%h wrap=%b, want F 8 1", bin, gray, wrap);
      end
      tick();
      checks++;
      if (bin !== 4'hE || gray !== 4'h9 || wrap !== 1'b0) begin
         errors++;
         $display("FAIL down_after_wrap: bin=%h gray=%h wrap=%b, want E 9 0", bin, gray, wrap);
      end
      en = 1'b0;
   endtask

   task automatic test_load_priority();
      load = 1'b1; load_bin = 4'h9; en = 1'b1; up = 1'b1;
      tick();
      checks++;
      if (bin !== 4'h9 || gray !== 4'hD || wrap !== 1'b0) begin
         errors++;
         $display("FAIL load_prio: bin=%h gray=%h wrap=%b, want 9 D 0", bin, gray, wrap);
      end
      load = 1'b0;
      tick();
      checks++;
      if (bin !== 4'hA || gray !== 4'hF) begin
         errors++;
         $display("FAIL load_then_up: bin=%h gray=%h, want A F", bin, gray);
      end
      en = 1'b0;
   endtask

   task automatic test_hold_reverse();
      load = 1'b1; load_bin = 4'h5; en = 1'b0;
      tick();
      load = 1'b0; en = 1'b0; up = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (bin !== 4'h5 || gray !== 4'h7 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL hold[%0d]: bin=%h gray=%h wrap=%b, want 5 7 0", i, bin, gray, wrap);
         end
      end
      en = 1'b1; up = 1'b0;
      tick();
      checks++;
      if (bin !== 4'h4 || gray !== 4'h6) begin
         errors++;
         $display("FAIL reverse: bin=%h gray=%h, want 4 6", bin, gray);
      end
      en = 1'b0;
   endtask

   task automatic test_mid_reset();
      load = 1'b1; load_bin = 4'hA; en = 1'b0;
      tick();
      load = 1'b0; en = 1'b1; up = 1'b1;
      tick();
      check_model("pre_mid_reset");
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (bin !== '0 || gray !== '0 || wrap !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: bin=%h gray=%h wrap=%b, want 0 0 0", bin, gray, wrap);
      end
      #4;
      rst = 1'b0;
      m_bin = 0; m_wrap = 1'b0;
      tick();
      checks++;
      if (bin !== 4'h1 || gray !== 4'h1 || wrap !== 1'b0) begin
         errors++;
         $display("FAIL after_mid_reset: bin=%h gray=%h wrap=%b, want 1 1 0", bin, gray, wrap);
      end
      en = 1'b0;
   endtask

   // Random load/enable/direction traffic; both wrap directions occur often.
   task automatic test_random();
      logic [WIDTH-1:0] prev;
      bit               stepped;
      for (int i = 0; i < 400; i++) begin
         load     = ($urandom_range(7) == 0);
         load_bin = WIDTH'($urandom_range(MODV - 1));
         en       = ($urandom_range(3) != 0);
         up       = ($urandom_range(1) == 1);
         stepped  = en && !load;
         prev     = gray;
         tick();
         check_model("random");
         if (stepped) begin
            checks++;
            if (popc(prev ^ gray) != 1) begin
               errors++;
               $display("FAIL random_onebit[%0d]: %h -> %h changes %0d bits, want 1",
                        i, prev, gray, popc(prev ^ gray));
            end
         end
      end
      load = 1'b0; en = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      m_bin  = 0;
      m_wrap = 1'b0;
      test_reset();
      test_up_count();
      test_down_wrap();
      test_load_priority();
      test_hold_reverse();
      test_mid_reset();
      do_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
